// File: rtl/div_requester.sv
// Sequences one divide job at a time: latch operands, pulse div_start, await the result, hand it back.
// Optional wait-timeout is compiled in when DIV_REQ_TIMEOUT_EN is defined.
module div_requester #(
  parameter int WIDTH          = 10,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_q,
  output logic [1:0]       resp_status,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_start,
  input  logic             div_busy,
  input  logic             div_valid,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_q,
  output logic [7:0]       job_count
);

  localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DIV_ERR = 2'b01;
`ifdef DIV_REQ_TIMEOUT_EN
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [7:0] TMO_LIMIT  = 8'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START_HI,
    START_LO,
    WAIT,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] resp_q_q, resp_q_d;
  logic [1:0]       resp_status_q, resp_status_d;
  logic [SCW-1:0]   start_cnt_q, start_cnt_d;
  logic [7:0]       job_count_q, job_count_d;
`ifdef DIV_REQ_TIMEOUT_EN
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
`endif

  // Only a solid logic 1 counts as a divider flag; x or z is treated as idle.
  logic valid_in;
  logic done_in;
  assign valid_in = (div_valid === 1'b1);
  assign done_in  = (div_done === 1'b1);

  // div_busy is purely observational and never steers the FSM.
  logic unused_inputs;
  assign unused_inputs = div_busy | (TIMEOUT_CYCLES == 0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      div_a_q       <= '0;
      div_b_q       <= '0;
      resp_q_q      <= '0;
      resp_status_q <= ST_OK;
      start_cnt_q   <= '0;
      job_count_q   <= '0;
`ifdef DIV_REQ_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      resp_q_q      <= resp_q_d;
      resp_status_q <= resp_status_d;
      start_cnt_q   <= start_cnt_d;
      job_count_q   <= job_count_d;
`ifdef DIV_REQ_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    div_a_d       = div_a_q;
    div_b_d       = div_b_q;
    resp_q_d      = resp_q_q;
    resp_status_d = resp_status_q;
    start_cnt_d   = start_cnt_q;
    job_count_d   = job_count_q;
`ifdef DIV_REQ_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          div_a_d     = req_a;
          div_b_d     = req_b;
          start_cnt_d = '0;
          state_d     = START_HI;
        end
      end

      START_HI: begin
        if (start_cnt_q == START_LAST) begin
          state_d = START_LO;
        end else begin
          start_cnt_d = start_cnt_q + 1'b1;
        end
      end

      START_LO: begin
        state_d = WAIT;
`ifdef DIV_REQ_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end

      WAIT: begin
`ifdef DIV_REQ_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
        // A real result beats an error flag, and either beats the timeout.
        if (valid_in) begin
          resp_q_d      = div_q;
          resp_status_d = ST_OK;
          state_d       = RESP;
        end else if (done_in) begin
          resp_q_d      = '0;
          resp_status_d = ST_DIV_ERR;
          state_d       = RESP;
        end
`ifdef DIV_REQ_TIMEOUT_EN
        else if (tmo_cnt_d == TMO_LIMIT) begin
          resp_q_d      = '0;
          resp_status_d = ST_TIMEOUT;
          state_d       = RESP;
        end
`endif
      end

      RESP: begin
        if (resp_ready) begin
          job_count_d = job_count_q + 8'd1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign div_start   = (state_q == START_HI);
  assign resp_valid  = (state_q == RESP);
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign resp_q      = resp_q_q;
  assign resp_status = resp_status_q;
  assign job_count   = job_count_q;

endmodule

// File: tb/tb_div_requester.sv
// Directed bench for div_requester: bench-driven divider model, inline checks per scenario task.
// Timeout scenario follows DIV_REQ_TIMEOUT_EN.
module tb_div_requester;

  localparam int WIDTH          = 10;
  localparam int START_CYCLES   = 2;
  localparam int TIMEOUT_CYCLES = 63;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [WIDTH-1:0] resp_q;
  logic [1:0]       resp_status;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_start;
  logic             div_busy = 1'b0;
  logic             div_valid = 1'b0;
  logic             div_done = 1'b0;
  logic [WIDTH-1:0] div_q = '0;
  logic [7:0]       job_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  div_requester #(
    .WIDTH(WIDTH),
    .START_CYCLES(START_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_q(resp_q),
    .resp_status(resp_status),
    .div_a(div_a),
    .div_b(div_b),
    .div_start(div_start),
    .div_busy(div_busy),
    .div_valid(div_valid),
    .div_done(div_done),
    .div_q(div_q),
    .job_count(job_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic to_wait();
    repeat (START_CYCLES + 1) tick();
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b expected 1", req_ready); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start: got %0b expected 0", div_start); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b expected 0", resp_valid); end
    checks++; if (job_count !== 8'd0) begin errors++; $display("FAIL reset_job_count: got %0d expected 0", job_count); end
    checks++; if (resp_q !== '0 || resp_status !== 2'b00) begin errors++; $display("FAIL reset_resp: got q=%0d st=%0d expected 0/0", resp_q, resp_status); end
    $display("reset: req_ready=%0b job_count=%0d", req_ready, job_count);
  endtask

  task automatic test_normal();
    int starts;
    int early_resp;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL normal_idle_ready: got %0b expected 1", req_ready); end
    accept(10'd100, 10'd7);
    checks++; if (div_a !== 10'd100 || div_b !== 10'd7) begin errors++; $display("FAIL normal_latch: got a=%0d b=%0d expected 100/7", div_a, div_b); end
    starts = 0;
    early_resp = 0;
    for (int i = 0; i < 12; i++) begin
      if (div_start === 1'b1) starts++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0) early_resp++;
      // stray divider flag before WAIT must be ignored
      div_done = (i == 0);
      tick();
    end
    div_done = 1'b0;
    checks++; if (starts !== START_CYCLES) begin errors++; $display("FAIL normal_start_cycles: got %0d expected %0d", starts, START_CYCLES); end
    checks++; if (early_resp !== 0) begin errors++; $display("FAIL normal_early_resp: got %0d bad cycles expected 0", early_resp); end
    div_valid = 1'b1;
    div_q     = 10'd14;
    tick();
    div_valid = 1'b0;
    div_q     = 10'd0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL normal_resp_valid: got %0b expected 1", resp_valid); end
    checks++; if (resp_q !== 10'd14 || resp_status !== 2'b00) begin errors++; $display("FAIL normal_resp: got q=%0d st=%0d expected 14/0", resp_q, resp_status); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL normal_resp_ready_low: got %0b expected 0", req_ready); end
    $display("job a=100 b=7 q=%0d status=%0d", resp_q, resp_status);
    handshake();
    checks++; if (job_count !== 8'd1 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL normal_complete: got cnt=%0d rv=%0b rr=%0b expected 1/0/1", job_count, resp_valid, req_ready); end
  endtask

  task automatic test_div_by_zero();
    accept(10'd50, 10'd0);
    to_wait();
    div_done = 1'b1;
    div_q    = 10'd33;
    tick();
    div_done = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_q !== 10'd0 || resp_status !== 2'b01) begin errors++; $display("FAIL div_zero: got rv=%0b q=%0d st=%0d expected 1/0/1", resp_valid, resp_q, resp_status); end
    $display("job a=50 b=0 q=%0d status=%0d", resp_q, resp_status);
    handshake();
    checks++; if (job_count !== 8'd2) begin errors++; $display("FAIL div_zero_count: got %0d expected 2", job_count); end
  endtask

  task automatic test_simultaneous();
    accept(10'd40, 10'd8);
    to_wait();
    div_valid = 1'b1;
    div_done  = 1'b1;
    div_q     = 10'd5;
    tick();
    div_valid = 1'b0;
    div_done  = 1'b0;
    checks++; if (resp_q !== 10'd5 || resp_status !== 2'b00) begin errors++; $display("FAIL simultaneous: got q=%0d st=%0d expected 5/0", resp_q, resp_status); end
    $display("job a=40 b=8 q=%0d status=%0d", resp_q, resp_status);
    handshake();
    checks++; if (job_count !== 8'd3) begin errors++; $display("FAIL simultaneous_count: got %0d expected 3", job_count); end
  endtask

  task automatic test_backpressure();
    accept(10'd200, 10'd3);
    to_wait();
    div_valid = 1'b1;
    div_q     = 10'd66;
    tick();
    div_valid = 1'b0;
    div_q     = 10'd123;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_q !== 10'd66 || resp_status !== 2'b00 || div_a !== 10'd200) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got rv=%0b q=%0d st=%0d a=%0d expected 1/66/0/200", i, resp_valid, resp_q, resp_status, div_a);
      end
      div_valid = (i == 4);
      tick();
    end
    div_valid = 1'b0;
    $display("job a=200 b=3 q=%0d status=%0d (held 10 cycles)", resp_q, resp_status);
    handshake();
    checks++; if (job_count !== 8'd4) begin errors++; $display("FAIL backpressure_count: got %0d expected 4", job_count); end
  endtask

  task automatic test_timeout();
    accept(10'd9, 10'd2);
    to_wait();
`ifdef DIV_REQ_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (resp_valid !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      checks++; if (n !== TIMEOUT_CYCLES) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", n, TIMEOUT_CYCLES); end
      checks++; if (resp_status !== 2'b10 || resp_q !== 10'd0) begin errors++; $display("FAIL timeout_resp: got q=%0d st=%0d expected 0/2", resp_q, resp_status); end
      $display("job a=9 b=2 q=%0d status=%0d (timeout)", resp_q, resp_status);
      handshake();
      checks++; if (job_count !== 8'd5) begin errors++; $display("FAIL timeout_count: got %0d expected 5", job_count); end
    end
`else
    begin
      int left_wait;
      left_wait = 0;
      for (int i = 0; i < 200; i++) begin
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) left_wait++;
        tick();
      end
      checks++; if (left_wait !== 0) begin errors++; $display("FAIL no_timeout_stays_wait: got %0d bad cycles expected 0", left_wait); end
      checks++; if (job_count !== 8'd4) begin errors++; $display("FAIL no_timeout_count: got %0d expected 4", job_count); end
      $display("job a=9 b=2 still waiting after 200 cycles");
    end
`endif
  endtask

  task automatic test_reset_mid();
    int stray;
    accept(10'd77, 10'd11);
    to_wait();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (req_ready !== 1'b1 || div_start !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_ctrl: got rr=%0b ds=%0b rv=%0b expected 1/0/0", req_ready, div_start, resp_valid); end
    checks++; if (div_a !== '0 || div_b !== '0 || resp_q !== '0 || resp_status !== 2'b00 || job_count !== 8'd0) begin errors++; $display("FAIL reset_mid_data: got a=%0d b=%0d q=%0d st=%0d cnt=%0d expected all 0", div_a, div_b, resp_q, resp_status, job_count); end
    accept(10'd5, 10'd5);
    reset = 1'b0;
    tick();
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_start_hi: got %0b expected 0", div_start); end
    reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid !== 1'b0 || div_start !== 1'b0) stray++;
      tick();
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL reset_abandon: got %0d bad cycles expected 0", stray); end
    $display("reset mid-job: job abandoned, job_count=%0d", job_count);
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] q;
    for (int j = 1; j <= 256; j++) begin
      q = WIDTH'(j % 256);
      accept(q, 10'd1);
      to_wait();
      div_valid = 1'b1;
      div_q     = q;
      tick();
      div_valid = 1'b0;
      checks++; if (resp_q !== q) begin errors++; $display("FAIL wrap_q[%0d]: got %0d expected %0d", j, resp_q, q); end
      handshake();
      $display("job %0d a=%0d b=1 q=%0d job_count=%0d", j, q, q, job_count);
      if (j == 255) begin
        checks++; if (job_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", job_count); end
      end
    end
    checks++; if (job_count !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", job_count); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_div_by_zero();
    test_simultaneous();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
